// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl_pkg
// Brief   : Shared CPU definitions for the hazard/stall controller: memory-wait
//           FSM state encoding and default register-address width.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  // Default architectural register-address width (32 registers)
  localparam int REG_W_DEF = 5;

  // Memory-wait FSM state encoding
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
// Module  : hazard_src_match
// Brief   : Per-operand comparator. Flags when a live, non-zero ID source
//           register equals the EX or MEM destination register.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_src_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             used_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic [REG_W-1:0] mem_dst_i,
  output logic             ex_hit_o,
  output logic             mem_hit_o
);

  logic w_live;

  // Register 0 is hard-wired to zero, so it can never carry a dependency
  always_comb begin
    w_live    = used_i && (src_i != '0);
    ex_hit_o  = w_live && (src_i == ex_dst_i);
    mem_hit_o = w_live && (src_i == mem_dst_i);
  end

endmodule : hazard_src_match
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : Pipeline hazard and stall controller. Detects load-use and
//           branch-operand hazards, freezes the pipe on data-memory waits,
//           raises a sticky memory timeout and keeps saturating counters of
//           stall and flush cycles.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     id_branch,
  input  logic                     id_jump,
  input  logic                     br_taken,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic [REG_W-1:0]         ex_dst,
  input  logic                     mem_memread,
  input  logic [REG_W-1:0]         mem_dst,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     ctrl_bubble,
  output logic                     pipe_freeze,
  output logic                     if_flush,
  output logic                     mem_timeout,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  // Timeout counter only needs to reach MEM_TMO; it holds there afterwards
  localparam int TMO_W = $clog2(MEM_TMO + 1);

  mem_state_e         state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic [NUM_SRC-1:0] w_ex_hit;
  logic [NUM_SRC-1:0] w_mem_hit;
  logic               w_load_use;
  logic               w_br_dep;
  logic               w_freeze;

  // One comparator per ID source operand
  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      hazard_src_match #(
        .REG_W (REG_W)
      ) u_match (
        .src_i     (id_src[k*REG_W +: REG_W]),
        .used_i    (id_src_used[k]),
        .ex_dst_i  (ex_dst),
        .mem_dst_i (mem_dst),
        .ex_hit_o  (w_ex_hit[k]),
        .mem_hit_o (w_mem_hit[k])
      );
    end
  endgenerate

  // Hazard classification; branches resolve in ID so they also wait on an
  // ALU result in EX or a load still in MEM
  always_comb begin
    w_load_use = ex_memread && (|w_ex_hit);
    w_br_dep   = id_branch && ((ex_regwrite && (|w_ex_hit)) ||
                               (mem_memread && (|w_mem_hit)));
    w_freeze   = ((state_q == MEM_WAIT) && !mem_ready) ||
                 ((state_q == IDLE) && mem_req && !mem_ready);
  end

  // Next-state and control outputs: freeze beats data hazard beats flush
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ctrl_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if_flush    = 1'b0;

    case (state_q)
      IDLE:     if (mem_req && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase

    if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (w_load_use || w_br_dep) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
    end else begin
      if_flush    = id_jump || (id_branch && br_taken);
    end
  end

  // Timeout, sticky flag and saturating performance counters
  always_comb begin
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    flush_d   = flush_q;

    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(MEM_TMO)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if ((state_q == MEM_WAIT) && (tmo_d == TMO_W'(MEM_TMO))) begin
      timeout_d = 1'b1;
    end

    if (!pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (if_flush  && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- REG_W, 5, register-address width.
- NUM_SRC, 2, number of ID-stage source operands checked.
- CNT_W, 16, width of the performance counters.
- MEM_TMO, 255, maximum memory-wait cycles before the timeout flag (at least 1).

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- id_src, in, NUM_SRC*REG_W, ID source register addresses; operand k is at bits [k*REG_W +: REG_W].
- id_src_used, in, NUM_SRC, per-operand valid.
- id_branch, in, 1, ID holds a beq or bne.
- id_jump, in, 1, ID holds a jump.
- br_taken, in, 1, branch condition true (ID comparator).
- ex_regwrite, in, 1, EX instruction writes a register.
- ex_memread, in, 1, EX instruction is a load.
- ex_dst, in, REG_W, EX destination after the RegDst mux.
- mem_memread, in, 1, MEM instruction is a load.
- mem_dst, in, REG_W, MEM destination.
- mem_req, in, 1, MEM stage issues a data-memory access.
- mem_ready, in, 1, data memory completes the access this cycle.
- pc_write, out, 1, PC update enable.
- ifid_write, out, 1, IF/ID write enable.
- ctrl_bubble, out, 1, 1 means zero the ID/EX control fields (insert a nop).
- pipe_freeze, out, 1, hold ID/EX, EX/MEM and MEM/WB.
- if_flush, out, 1, clear IF/ID.
- mem_timeout, out, 1, sticky flag: the memory wait exceeded MEM_TMO.
- stall_cnt, out, CNT_W, count of cycles with pc_write=0.
- flush_cnt, out, CNT_W, count of cycles with if_flush=1.

Function
REQ-003 A source operand k SHALL match when id_src_used[k]=1 and its address is non-zero. Register 0 SHALL never cause a hazard.
REQ-004 load_use SHALL be true when ex_memread=1 and ex_dst equals any matching operand.
REQ-005 br_dep SHALL be true when id_branch=1 and any matching operand equals either:
- ex_dst with ex_regwrite=1, or
- mem_dst with mem_memread=1.
REQ-006 Data hazard SHALL be load_use OR br_dep. A load in EX feeding a branch therefore stalls 2 cycles.
REQ-007 The FSM SHALL have states IDLE and MEM_WAIT, with these transitions:
- IDLE to MEM_WAIT when mem_req=1 and mem_ready=0.
- MEM_WAIT to IDLE on the cycle mem_ready=1.
REQ-008 Freeze SHALL be true when either holds:
- the state is MEM_WAIT and mem_ready=0, or
- the state is IDLE, mem_req=1 and mem_ready=0.
REQ-009 While freeze is true, outputs SHALL be pc_write=0, ifid_write=0, pipe_freeze=1, ctrl_bubble=0 and if_flush=0. Freeze overrides every other condition.
REQ-010 On a data hazard without freeze, outputs SHALL be pc_write=0, ifid_write=0, ctrl_bubble=1, pipe_freeze=0 and if_flush=0.
REQ-011 With no hazard and no freeze, pc_write, ifid_write and ctrl_bubble SHALL be 1, 1 and 0. if_flush SHALL equal id_jump OR (id_branch AND br_taken).
REQ-012 All control outputs SHALL be combinational from the inputs and the registered state, with zero-cycle latency.
REQ-013 A timeout counter SHALL clear in IDLE and increment each MEM_WAIT cycle. When it reaches MEM_TMO, mem_timeout SHALL set and stay set until reset. The FSM SHALL continue waiting.
REQ-014 stall_cnt SHALL increment on every cycle with pc_write=0, and flush_cnt on every cycle with if_flush=1. Both SHALL saturate at all-ones and never wrap.
REQ-015 If mem_req and mem_ready are both 1 in IDLE, no freeze SHALL occur and the state SHALL remain IDLE.

Reset
REQ-016 While rst_n=0, the following SHALL be forced immediately, independent of clk:
- state = IDLE;
- timeout counter = 0, mem_timeout = 0;
- stall_cnt = 0, flush_cnt = 0.
REQ-017 Reset asserted in MEM_WAIT SHALL abandon the wait. After release, outputs SHALL follow REQ-009 to REQ-011 from IDLE.
REQ-018 During reset, the control outputs SHALL reflect the IDLE state and the current inputs.

Structure
REQ-019 The FSM state encoding and the default REG_W SHALL live in the shared CPU package. Parameters SHALL stay module-local.
REQ-020 The per-operand comparator SHALL be one sub-module, hazard_src_match, instantiated NUM_SRC times via generate. Everything else SHALL be flat.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Load-use: ex_memread=1, ex_dst=8, id_src={8,3}, used=2'b11 -> one cycle with pc_write=0 and ctrl_bubble=1; stall_cnt=1.
- Zero register: ex_memread=1, ex_dst=0, id_src={0,0} -> no stall; pc_write=1.
- Load then branch: ex_memread=1, ex_dst=5, id_branch=1, id_src={5,0}; next cycle mem_memread=1, mem_dst=5 -> 2 stall cycles, then taken branch with br_taken=1 -> if_flush=1 for 1 cycle; flush_cnt=1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> pipe_freeze=1 and ctrl_bubble=0 for 3 cycles; release on the cycle mem_ready=1; a jump presented during the wait gives if_flush=0.
- Timeout and saturation: MEM_TMO=4 with mem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays high; with CNT_W=4, 20 stall cycles -> stall_cnt=15.
- Reset during wait: rst_n pulsed low mid-MEM_WAIT -> state IDLE, counters 0, mem_timeout 0 immediately.
